// File: rtl/c7bexu_issue_pkg.sv
// Shared definitions for the EXU issue/stall/flush block: FSM states,
// writeback source selects and default latency/timeout values.
package c7bexu_issue_pkg;

  typedef enum logic [1:0] {
    EXU_IDLE     = 2'd0,
    EXU_LSU_BUSY = 2'd1,
    EXU_MUL_BUSY = 2'd2
  } exu_state_e;

  localparam logic [1:0] ECL_SEL_ALU = 2'd0;
  localparam logic [1:0] ECL_SEL_LSU = 2'd1;
  localparam logic [1:0] ECL_SEL_MUL = 2'd2;

  localparam int unsigned MUL_LAT_DEF = 2;
  localparam int unsigned LSU_TMO_DEF = 255;
  localparam int unsigned BUSY_CNT_W  = 8;

endpackage

// File: rtl/c7bexu_busy_cnt.sv
// Loadable down-counter shared by the MUL latency and the LSU timeout.
// expire flags the enabled cycle in which the count steps from 1 to 0.
module c7bexu_busy_cnt
  import c7bexu_issue_pkg::*;
#(
  parameter int unsigned W = BUSY_CNT_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = en & (cnt == W'(1));

endmodule

// File: rtl/c7bexu_issue.sv
// EXU issue control: stall/flush to IFU and RF writeback control.
// Optional LSU timeout is enabled by defining C7B_LSU_TMO_EN (LSU_TMO 1..255).
module c7bexu_issue
  import c7bexu_issue_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned LSU_TMO = LSU_TMO_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ifu_exu_vld_d,
  input  logic [4:0] ifu_exu_rd_d,
  input  logic       ifu_exu_wen_d,
  input  logic       ifu_exu_alu_vld_d,
  input  logic       ifu_exu_lsu_vld_d,
  input  logic       ifu_exu_mul_vld_d,
  input  logic       ifu_exu_bru_vld_d,
  input  logic       ifu_exu_csr_vld_d,
  input  logic       ifu_exu_ertn_vld_d,
  input  logic       dec_exc_vld_d,
  input  logic       bru_taken_d,
  input  logic       lsu_ecl_done,
  output logic       exu_ifu_stall,
  output logic       exu_ifu_flush,
  output logic       ecl_rf_wen_w,
  output logic [4:0] ecl_rf_waddr_w,
  output logic [1:0] ecl_rf_sel_w,
  output logic       ecl_lsu_tmo
);

  exu_state_e state, state_nxt;
  logic [4:0] lat_rd;
  logic       lat_wen;

  logic issue_ok, issue_lsu, issue_mul, issue_single, mul_single;
  logic cnt_load, cnt_en, cnt_expire, lsu_tmo_hit;
  logic [BUSY_CNT_W-1:0] cnt_load_val;

  // Excepting instructions neither write back nor start a multi-cycle op.
  assign issue_ok     = ifu_exu_vld_d & ~dec_exc_vld_d & (state == EXU_IDLE);
  assign issue_lsu    = issue_ok & ifu_exu_lsu_vld_d;
  assign issue_mul    = issue_ok & ~ifu_exu_lsu_vld_d & ifu_exu_mul_vld_d;
  assign issue_single = issue_ok & ~ifu_exu_lsu_vld_d & ~ifu_exu_mul_vld_d &
                        (ifu_exu_alu_vld_d | ifu_exu_bru_vld_d | ifu_exu_csr_vld_d);
  assign mul_single   = issue_mul & (MUL_LAT == 1);

  assign cnt_load     = issue_lsu | issue_mul;
  assign cnt_load_val = issue_lsu ? BUSY_CNT_W'(LSU_TMO) : BUSY_CNT_W'(MUL_LAT - 1);

`ifdef C7B_LSU_TMO_EN
  assign cnt_en      = (state == EXU_MUL_BUSY) | (state == EXU_LSU_BUSY);
  assign lsu_tmo_hit = (state == EXU_LSU_BUSY) & cnt_expire & ~lsu_ecl_done;
`else
  assign cnt_en      = (state == EXU_MUL_BUSY);
  assign lsu_tmo_hit = 1'b0;
`endif

  c7bexu_busy_cnt #(
    .W (BUSY_CNT_W)
  ) u_busy_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .expire   (cnt_expire)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= EXU_IDLE;
      lat_rd  <= '0;
      lat_wen <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_load) begin
        lat_rd  <= ifu_exu_rd_d;
        lat_wen <= ifu_exu_wen_d;
      end
    end
  end

  // Outputs are forced low while reset is asserted so an abandoned op never writes back.
  always_comb begin
    state_nxt      = state;
    exu_ifu_stall  = 1'b0;
    exu_ifu_flush  = 1'b0;
    ecl_rf_wen_w   = 1'b0;
    ecl_rf_waddr_w = '0;
    ecl_rf_sel_w   = ECL_SEL_ALU;
    ecl_lsu_tmo    = 1'b0;
    if (resetn) begin
      exu_ifu_stall = (state != EXU_IDLE);
      exu_ifu_flush = (ifu_exu_vld_d & (dec_exc_vld_d | ifu_exu_ertn_vld_d |
                                        (ifu_exu_bru_vld_d & bru_taken_d))) | lsu_tmo_hit;
      ecl_lsu_tmo   = lsu_tmo_hit;
      case (state)
        EXU_IDLE: begin
          if (issue_lsu) begin
            state_nxt = EXU_LSU_BUSY;
          end else if (issue_mul && !mul_single) begin
            state_nxt = EXU_MUL_BUSY;
          end
          if (issue_single || mul_single) begin
            ecl_rf_wen_w   = ifu_exu_wen_d;
            ecl_rf_waddr_w = ifu_exu_rd_d;
            ecl_rf_sel_w   = mul_single ? ECL_SEL_MUL : ECL_SEL_ALU;
          end
        end
        EXU_LSU_BUSY: begin
          if (lsu_ecl_done) begin
            ecl_rf_wen_w   = lat_wen;
            ecl_rf_waddr_w = lat_rd;
            ecl_rf_sel_w   = ECL_SEL_LSU;
            state_nxt      = EXU_IDLE;
          end else if (lsu_tmo_hit) begin
            state_nxt = EXU_IDLE;
          end
        end
        EXU_MUL_BUSY: begin
          if (cnt_expire) begin
            ecl_rf_wen_w   = lat_wen;
            ecl_rf_waddr_w = lat_rd;
            ecl_rf_sel_w   = ECL_SEL_MUL;
            state_nxt      = EXU_IDLE;
          end
        end
        default: state_nxt = EXU_IDLE;
      endcase
    end
  end

endmodule

// File: doc/c7bexu_issue.md
Name: c7bexu_issue

Overview:
- EXU-side receiver of the IFU decode-stage bundle; sits directly after the IFU decode stage.
- Accepts decoded instructions from IFU and decides issue, stall and flush.
- Drives stall/flush back to IFU for long-latency ops (LSU, multi-cycle MUL) and for redirects (exception, ertn, taken branch).
- Latches rd/wen across multi-cycle ops and produces writeback control for the register file.

Parameters:
- MUL_LAT, 2: cycles a MUL occupies the EXU, 1..15.
- LSU_TMO, 255: timeout threshold in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- ifu_exu_vld_d  in  1  valid decoded instruction; already gated by stall
- ifu_exu_rd_d  in  5  destination register
- ifu_exu_wen_d  in  1  GR write enable
- ifu_exu_alu_vld_d  in  1  ALU op
- ifu_exu_lsu_vld_d  in  1  LSU op
- ifu_exu_mul_vld_d  in  1  MUL op
- ifu_exu_bru_vld_d  in  1  branch op
- ifu_exu_csr_vld_d  in  1  CSR op
- ifu_exu_ertn_vld_d  in  1  ertn
- dec_exc_vld_d  in  1  decode exception
- bru_taken_d  in  1  branch resolved taken, same cycle
- lsu_ecl_done  in  1  LSU access complete, one-cycle pulse
- exu_ifu_stall  out  1  stall to IFU
- exu_ifu_flush  out  1  flush to IFU
- ecl_rf_wen_w  out  1  register-file write enable
- ecl_rf_waddr_w  out  5  write address
- ecl_rf_sel_w  out  2  write source: 0 ALU/BRU/CSR, 1 LSU, 2 MUL
- ecl_lsu_tmo  out  1  LSU timeout exception pulse; tied 0 without the optional feature

Behaviour:
- Reset (resetn=0 at posedge): state IDLE, counters 0, latched rd/wen 0, all outputs 0.
- FSM states IDLE, LSU_BUSY, MUL_BUSY.
- IDLE:
  - ifu_exu_vld_d & lsu_vld: capture rd/wen, go to LSU_BUSY.
  - ifu_exu_vld_d & mul_vld: capture rd/wen, load counter with MUL_LAT-1, go to MUL_BUSY. If MUL_LAT=1, stay IDLE and write back at the next edge.
- exu_ifu_stall = (state != IDLE), registered. The younger instruction entering D the cycle after issue is therefore held, with its valid suppressed.
- LSU_BUSY:
  - Exit on lsu_ecl_done.
  - That cycle: ecl_rf_wen_w = latched wen, waddr = latched rd, sel=1. Return to IDLE; stall drops the next cycle.
  - lsu_ecl_done in IDLE or MUL_BUSY is ignored.
- MUL_BUSY:
  - Counter decrements each cycle.
  - At 0: write back with sel=2, go to IDLE.
- Single-cycle ops (alu/bru/csr) with ifu_exu_vld_d: combinational writeback the same cycle, wen=ifu_exu_wen_d, waddr=ifu_exu_rd_d, sel=0. A single-cycle op and a multi-cycle completion cannot coincide, because stall blocks issue.
- Flush, combinational: exu_ifu_flush = ifu_exu_vld_d & (dec_exc_vld_d | ertn_vld | (bru_vld & bru_taken_d)).
  - Exception instructions never write the RF and never start the FSM.
  - Flush while stalled is impossible, since valid is gated.
- Writes to waddr 0 are passed through; the RF ignores them.
- Reset mid-operation abandons the op: no writeback, stall cleared the next cycle.

Optional Feature:
- Macro C7B_LSU_TMO_EN.
- With it: an 8-bit counter runs in LSU_BUSY. On reaching LSU_TMO without lsu_ecl_done:
  - pulse ecl_lsu_tmo and exu_ifu_flush for one cycle;
  - return to IDLE with no writeback.
  - Done and timeout in the same cycle: done wins.
- Without it: no counter, ecl_lsu_tmo=0, LSU_BUSY waits indefinitely.

Decomposition:
- Shared package/defs header: FSM state encodings, ECL_SEL_ALU/LSU/MUL constants, default MUL_LAT/LSU_TMO.
- One sub-module, c7bexu_busy_cnt: down-counter with load/done, reused for the MUL latency and the LSU timeout.

Test Plan:
- Reset: hold resetn=0 two cycles with vld=1 -> all outputs 0, state IDLE.
- ALU op (vld=1, alu, rd=5, wen=1) -> same-cycle wen_w=1, waddr=5, sel=0, stall stays 0.
- LSU op (rd=7, wen=1), done 4 cycles later -> stall=1 for 4 cycles; writeback waddr=7, sel=1 on the done cycle; stall=0 the next cycle.
- MUL op (rd=9), MUL_LAT=3 -> stall 1 for 2 cycles; writeback waddr=9, sel=2 at cycle issue+2.
- Taken branch (bru_vld, bru_taken_d=1) -> flush=1 the same cycle. Syscall (dec_exc_vld_d=1, wen=1) -> flush=1, wen_w=0.
- C7B_LSU_TMO_EN, LSU_TMO=10, no done -> ecl_lsu_tmo and flush pulse at cycle 10, no writeback. Done at cycle 10 -> writeback, no timeout pulse.
